// File: rtl/alu_exec_unit.sv
// Execute stage: decodes ALUctr/func and runs single-cycle ALU ops or an
// iterative shift-add multiplier / restoring divider writing HI/LO.
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int OP_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       ALUctr,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [OP_W-1:0]  op_code,
  output logic             zero,
  output logic             overflow,
  output logic             illegal,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,  OP_SUB   = 4'd1,  OP_AND  = 4'd2,  OP_OR   = 4'd3,
    OP_XOR   = 4'd4,  OP_NOR   = 4'd5,  OP_SLT  = 4'd6,  OP_SLTU = 4'd7,
    OP_MFHI  = 4'd8,  OP_MFLO  = 4'd9,  OP_MULT = 4'd10, OP_MULTU = 4'd11,
    OP_DIV   = 4'd12, OP_DIVU  = 4'd13, OP_ILL  = 4'd15
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e             state_r, next_s;
  op_e                op_s;
  logic               ready_r, out_valid_r;
  logic [WIDTH-1:0]   result_r, hi_r, lo_r;
  logic [OP_W-1:0]    op_code_r;
  logic               zero_r, overflow_r, illegal_r, div_zero_r;
  logic [CW-1:0]      cnt_r;
  // Upper half: accumulator (mul) or partial remainder (div); lower half:
  // multiplier bits (mul) or dividend/quotient bits (div).
  logic [2*WIDTH-1:0] acc_r;
  logic [WIDTH-1:0]   opnd_r;
  logic               is_div_r, neg_lo_r, neg_hi_r;

  logic [WIDTH-1:0]   res_s, sum_s, diff_s, abs_a_s, abs_b_s;
  logic               ovf_s, ill_s, accept_s, is_mul_s, is_div_s, signed_s, sign_diff_s;
  logic [WIDTH:0]     mul_sum_s, div_shift_s, div_trial_s;
  logic [2*WIDTH-1:0] prod_neg_s;
  logic [WIDTH-1:0]   fin_hi_s, fin_lo_s;

  assign in_ready  = ready_r;
  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign op_code   = op_code_r;
  assign zero      = zero_r;
  assign overflow  = overflow_r;
  assign illegal   = illegal_r;
  assign div_zero  = div_zero_r;
  assign hi        = hi_r;
  assign lo        = lo_r;

  // Decode ALUctr/func into an internal operation.
  always_comb begin
    op_s = OP_ILL;
    case (ALUctr)
      2'b00: op_s = OP_ADD;
      2'b01: op_s = OP_SUB;
      2'b11: op_s = OP_OR;
      2'b10: begin
        case (func)
          6'b100000: op_s = OP_ADD;
          6'b100010: op_s = OP_SUB;
          6'b100100: op_s = OP_AND;
          6'b100101: op_s = OP_OR;
          6'b100110: op_s = OP_XOR;
          6'b100111: op_s = OP_NOR;
          6'b101010: op_s = OP_SLT;
          6'b101011: op_s = OP_SLTU;
          6'b010000: op_s = OP_MFHI;
          6'b010010: op_s = OP_MFLO;
          6'b011000: op_s = OP_MULT;
          6'b011001: op_s = OP_MULTU;
          6'b011010: op_s = OP_DIV;
          6'b011011: op_s = OP_DIVU;
          default:   op_s = OP_ILL;
        endcase
      end
      default: op_s = OP_ILL;
    endcase
  end

  assign sum_s       = src_a + src_b;
  assign diff_s      = src_a - src_b;
  assign accept_s    = in_valid & ready_r;
  assign is_mul_s    = (op_s == OP_MULT) || (op_s == OP_MULTU);
  assign is_div_s    = (op_s == OP_DIV)  || (op_s == OP_DIVU);
  assign signed_s    = (op_s == OP_MULT) || (op_s == OP_DIV);
  assign sign_diff_s = signed_s & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
  assign abs_a_s     = (signed_s && src_a[WIDTH-1]) ? (~src_a + {{(WIDTH-1){1'b0}}, 1'b1}) : src_a;
  assign abs_b_s     = (signed_s && src_b[WIDTH-1]) ? (~src_b + {{(WIDTH-1){1'b0}}, 1'b1}) : src_b;

  // Single-cycle result and flags.
  always_comb begin
    res_s = {WIDTH{1'b0}};
    ovf_s = 1'b0;
    ill_s = 1'b0;
    case (op_s)
      OP_ADD: begin
        res_s = sum_s;
        ovf_s = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (sum_s[WIDTH-1] != src_a[WIDTH-1]);
      end
      OP_SUB: begin
        res_s = diff_s;
        ovf_s = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (diff_s[WIDTH-1] != src_a[WIDTH-1]);
      end
      OP_AND:  res_s = src_a & src_b;
      OP_OR:   res_s = src_a | src_b;
      OP_XOR:  res_s = src_a ^ src_b;
      OP_NOR:  res_s = ~(src_a | src_b);
      OP_SLT:  res_s = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      OP_SLTU: res_s = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
      OP_MFHI: res_s = hi_r;
      OP_MFLO: res_s = lo_r;
      OP_ILL:  ill_s = 1'b1;
      default: res_s = {WIDTH{1'b0}};
    endcase
  end

  // One iteration step of the multiplier and divider, plus final sign fix-up.
  always_comb begin
    mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} +
                  (acc_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
    div_shift_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
    div_trial_s = div_shift_s - {1'b0, opnd_r};
    prod_neg_s  = ~acc_r + {{(2*WIDTH-1){1'b0}}, 1'b1};
    if (is_div_r) begin
      fin_lo_s = neg_lo_r ? (~acc_r[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, 1'b1}) : acc_r[WIDTH-1:0];
      fin_hi_s = neg_hi_r ? (~acc_r[2*WIDTH-1:WIDTH] + {{(WIDTH-1){1'b0}}, 1'b1})
                          : acc_r[2*WIDTH-1:WIDTH];
    end else begin
      fin_lo_s = neg_lo_r ? prod_neg_s[WIDTH-1:0] : acc_r[WIDTH-1:0];
      fin_hi_s = neg_lo_r ? prod_neg_s[2*WIDTH-1:WIDTH] : acc_r[2*WIDTH-1:WIDTH];
    end
  end

  // FSM next-state; divide by zero never leaves IDLE.
  always_comb begin
    next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && is_mul_s) begin
          next_s = ST_MUL;
        end else if (accept_s && is_div_s && (src_b != {WIDTH{1'b0}})) begin
          next_s = ST_DIV;
        end else begin
          next_s = ST_IDLE;
        end
      end
      ST_MUL:  next_s = (cnt_r == CW'(WIDTH - 1)) ? ST_DONE : ST_MUL;
      ST_DIV:  next_s = (cnt_r == CW'(WIDTH - 1)) ? ST_DONE : ST_DIV;
      ST_DONE: next_s = ST_IDLE;
      default: next_s = ST_IDLE;
    endcase
  end

  // State register; in_ready is registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      ready_r <= 1'b1;
    end else begin
      state_r <= next_s;
      ready_r <= (next_s == ST_IDLE);
    end
  end

  // Datapath, result and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      result_r    <= {WIDTH{1'b0}};
      op_code_r   <= {OP_W{1'b0}};
      zero_r      <= 1'b0;
      overflow_r  <= 1'b0;
      illegal_r   <= 1'b0;
      div_zero_r  <= 1'b0;
      hi_r        <= {WIDTH{1'b0}};
      lo_r        <= {WIDTH{1'b0}};
      cnt_r       <= {CW{1'b0}};
      acc_r       <= {(2*WIDTH){1'b0}};
      opnd_r      <= {WIDTH{1'b0}};
      is_div_r    <= 1'b0;
      neg_lo_r    <= 1'b0;
      neg_hi_r    <= 1'b0;
    end else begin
      out_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            op_code_r <= OP_W'(op_s);
            if (is_mul_s) begin
              acc_r    <= {{WIDTH{1'b0}}, abs_b_s};
              opnd_r   <= abs_a_s;
              cnt_r    <= {CW{1'b0}};
              is_div_r <= 1'b0;
              neg_lo_r <= sign_diff_s;
              neg_hi_r <= 1'b0;
            end else if (is_div_s && (src_b == {WIDTH{1'b0}})) begin
              hi_r        <= src_a;
              lo_r        <= {WIDTH{1'b1}};
              result_r    <= {WIDTH{1'b1}};
              out_valid_r <= 1'b1;
              zero_r      <= 1'b0;
              overflow_r  <= 1'b0;
              illegal_r   <= 1'b0;
              div_zero_r  <= 1'b1;
            end else if (is_div_s) begin
              acc_r    <= {{WIDTH{1'b0}}, abs_a_s};
              opnd_r   <= abs_b_s;
              cnt_r    <= {CW{1'b0}};
              is_div_r <= 1'b1;
              neg_lo_r <= sign_diff_s;
              neg_hi_r <= signed_s & src_a[WIDTH-1];
            end else begin
              result_r    <= res_s;
              out_valid_r <= 1'b1;
              zero_r      <= (res_s == {WIDTH{1'b0}});
              overflow_r  <= ovf_s;
              illegal_r   <= ill_s;
              div_zero_r  <= 1'b0;
            end
          end
        end
        ST_MUL: begin
          acc_r <= {mul_sum_s, acc_r[WIDTH-1:1]};
          cnt_r <= cnt_r + CW'(1);
        end
        ST_DIV: begin
          if (!div_trial_s[WIDTH]) begin
            acc_r <= {div_trial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
          end else begin
            acc_r <= {div_shift_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
          end
          cnt_r <= cnt_r + CW'(1);
        end
        ST_DONE: begin
          hi_r        <= fin_hi_s;
          lo_r        <= fin_lo_s;
          result_r    <= fin_lo_s;
          out_valid_r <= 1'b1;
          zero_r      <= (fin_lo_s == {WIDTH{1'b0}});
          overflow_r  <= 1'b0;
          illegal_r   <= 1'b0;
          div_zero_r  <= 1'b0;
        end
        default: out_valid_r <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: vector table for single-cycle ops,
// hand sequences for multiply/divide, divide-by-zero and mid-op reset.
module tb_alu_exec_unit;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    ALUctr = 2'b00;
  logic [5:0]    func = 6'b000000;
  logic [W-1:0]  src_a = 32'd0, src_b = 32'd0;
  logic          out_valid;
  logic [W-1:0]  result, hi, lo;
  logic [3:0]    op_code;
  logic          zero, overflow, illegal, div_zero;

  alu_exec_unit #(.WIDTH(W), .OP_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ALUctr(ALUctr), .func(func), .src_a(src_a), .src_b(src_b),
    .out_valid(out_valid), .result(result), .op_code(op_code),
    .zero(zero), .overflow(overflow), .illegal(illegal), .div_zero(div_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  c;
    logic [5:0]  f;
    logic [31:0] a, b, res;
    logic        z, ov, il;
  } vec_t;

  typedef struct {
    int          id;
    logic [31:0] res;
    logic        z, ov, il, dz, hl;
    logic [31:0] hi, lo;
  } exp_t;

  int   checks = 0;
  int   fails = 0;
  exp_t sb[$];
  vec_t v[14];

  function automatic exp_t mk(input int id, input logic [31:0] res, input logic z, ov, il, dz,
                              input logic hl, input logic [31:0] h, l);
    exp_t e;
    e.id = id; e.res = res; e.z = z; e.ov = ov; e.il = il; e.dz = dz;
    e.hl = hl; e.hi = h; e.lo = l;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_out_valid: got result %h with no pending op", result);
        end else begin
          e = sb.pop_front();
          chk($sformatf("result#%0d", e.id), 64'(result), 64'(e.res));
          chk($sformatf("zero#%0d", e.id), 64'(zero), 64'(e.z));
          chk($sformatf("overflow#%0d", e.id), 64'(overflow), 64'(e.ov));
          chk($sformatf("illegal#%0d", e.id), 64'(illegal), 64'(e.il));
          chk($sformatf("div_zero#%0d", e.id), 64'(div_zero), 64'(e.dz));
          if (e.hl) begin
            chk($sformatf("hi#%0d", e.id), 64'(hi), 64'(e.hi));
            chk($sformatf("lo#%0d", e.id), 64'(lo), 64'(e.lo));
          end
        end
      end
    end
  endtask

  task automatic issue(input logic [1:0] c, input logic [5:0] f, input logic [31:0] a, b,
                       input exp_t e, input logic push);
    @(negedge clk);
    ALUctr = c; func = f; src_a = a; src_b = b; in_valid = 1'b1;
    if (push) sb.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Issue a mult/div, hold garbage on the inputs while busy, count stall cycles.
  task automatic multi(input string nm, input logic [5:0] f, input logic [31:0] a, b, input exp_t e);
    int n;
    issue(2'b10, f, a, b, e, 1'b1);
    @(negedge clk);
    ALUctr = 2'b00; src_a = 32'hDEAD_BEEF; src_b = 32'h1111_1111;
    n = 0;
    while (!in_ready && n < 200) begin
      n++;
      if (n == 5) in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk({nm, "_busy_cycles"}, 64'(n), 64'd33);
    chk({nm, "_done_pulse"}, 64'(out_valid), 64'd1);
  endtask

  initial begin
    v[0]  = '{2'b10, 6'b100000, 32'd7,          32'd5,          32'd12,         1'b0, 1'b0, 1'b0};
    v[1]  = '{2'b00, 6'b000000, 32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  1'b0, 1'b1, 1'b0};
    v[2]  = '{2'b01, 6'b111111, 32'h1234,       32'h1234,       32'd0,          1'b1, 1'b0, 1'b0};
    v[3]  = '{2'b10, 6'b111111, 32'd9,          32'd3,          32'd0,          1'b1, 1'b0, 1'b1};
    v[4]  = '{2'b10, 6'b100010, 32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  1'b0, 1'b1, 1'b0};
    v[5]  = '{2'b10, 6'b100100, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000,  1'b0, 1'b0, 1'b0};
    v[6]  = '{2'b11, 6'b000000, 32'h00FF_0000,  32'h0000_FF00,  32'h00FF_FF00,  1'b0, 1'b0, 1'b0};
    v[7]  = '{2'b10, 6'b100110, 32'hAAAA_5555,  32'hFFFF_0000,  32'h5555_5555,  1'b0, 1'b0, 1'b0};
    v[8]  = '{2'b10, 6'b100111, 32'h0F0F_0F0F,  32'h3030_3030,  32'hC0C0_C0C0,  1'b0, 1'b0, 1'b0};
    v[9]  = '{2'b10, 6'b101010, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0, 1'b0, 1'b0};
    v[10] = '{2'b10, 6'b101011, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1, 1'b0, 1'b0};
    v[11] = '{2'b10, 6'b100000, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1, 1'b0, 1'b0};
    v[12] = '{2'b10, 6'b100010, 32'd0,          32'h8000_0000,  32'h8000_0000,  1'b0, 1'b1, 1'b0};
    v[13] = '{2'b10, 6'b100001, 32'd4,          32'd4,          32'd0,          1'b1, 1'b0, 1'b1};

    fork
      monitor();
    join_none

    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_flags", 64'({zero, overflow, illegal, div_zero}), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      issue(v[i].c, v[i].f, v[i].a, v[i].b,
            mk(i, v[i].res, v[i].z, v[i].ov, v[i].il, 1'b0, 1'b0, 32'd0, 32'd0), 1'b1);
    end
    idle();
    @(negedge clk);
    chk("hold_out_valid", 64'(out_valid), 64'd0);
    chk("hold_illegal", 64'(illegal), 64'd1);
    chk("hold_zero", 64'(zero), 64'd1);

    multi("mult", 6'b011000, 32'hFFFF_FFFD, 32'd5,
          mk(100, 32'hFFFF_FFF1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1));
    issue(2'b10, 6'b010000, 32'd0, 32'd0,
          mk(101, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1), 1'b1);
    issue(2'b10, 6'b010010, 32'd0, 32'd0,
          mk(102, 32'hFFFF_FFF1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1), 1'b1);
    idle();

    multi("div", 6'b011010, 32'hFFFF_FFF9, 32'd2,
          mk(103, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD));
    issue(2'b10, 6'b011010, 32'd7, 32'd0,
          mk(104, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd7, 32'hFFFF_FFFF), 1'b1);
    idle();
    chk("divz_ready", 64'(in_ready), 64'd1);
    chk("divz_pulse", 64'(out_valid), 64'd1);

    multi("divu", 6'b011011, 32'd100, 32'd7,
          mk(105, 32'd14, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd2, 32'd14));
    multi("divovf", 6'b011010, 32'h8000_0000, 32'hFFFF_FFFF,
          mk(106, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'h8000_0000));
    multi("multu", 6'b011001, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
          mk(107, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001));
    multi("multmin", 6'b011000, 32'h8000_0000, 32'h8000_0000,
          mk(108, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h4000_0000, 32'd0));

    issue(2'b10, 6'b011001, 32'hFFFF_FFFF, 32'd3, mk(0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0), 1'b0);
    idle();
    repeat (9) @(negedge clk);
    chk("prerst_busy", 64'(in_ready), 64'd0);
    chk("prerst_hi", 64'(hi), 64'h4000_0000);
    rst_n = 1'b0;
    #1;
    chk("midrst_hilo", {hi, lo}, 64'd0);
    chk("midrst_ready", 64'(in_ready), 64'd1);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_rst_hilo", {hi, lo}, 64'd0);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
